base_arbiter: RTL and testbench

BASE_ARBITER -- requirements
Module: base_arbiter

---
 rtl/base_arbiter.sv | 126 ++++++++++++
 tb/tb_base_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/base_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant,
// mandatory idle gap between grants and an optional hold-time limit.
module base_arbiter #(
  parameter logic [7:0] HOLD_MAX = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter value seen on the last cycle a grant may be held
  localparam logic [7:0] HOLD_LAST = HOLD_MAX - 8'd1;

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] id_q, id_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       to_q, to_d;

  logic [1:0] win;
  logic       win_found;
  logic       hold_hit;

  // Round-robin search starting one above the last owner, wrapping around
  always_comb begin : pick_winner
    logic [1:0] idx;
    idx       = '0;
    win       = '0;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!win_found && req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  // Hold limit reached on this cycle; a zero limit never fires
  always_comb begin
    hold_hit = (HOLD_MAX != 8'd0) && (cnt_q == HOLD_LAST);
  end

  // Next-state logic: grant from IDLE, release on owner done or hold limit
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d = BUSY;
          last_d  = win;
          id_d    = win;
          cnt_d   = '0;
          gnt_d   = 4'b0001 << win;
        end
      end
      BUSY: begin
        // Owner release takes precedence, so a simultaneous limit is not a timeout
        if (done[id_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (hold_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          to_d    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State register; reset gives requester 0 first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      id_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state_q == BUSY);
  assign timeout   = to_q;

  // Grant vector always matches the owner index
  a_gnt_decode: assert property (@(posedge clk) disable iff (!rst_n)
    gnt == (gnt_valid ? (4'b0001 << gnt_id) : 4'b0000));

  // A timeout pulse only ever appears during the idle gap
  a_to_idle: assert property (@(posedge clk) disable iff (!rst_n)
    timeout |-> !gnt_valid);

endmodule

// File: tb/tb_base_arbiter.sv
// Bench for base_arbiter: directed vector table, hand-written corner
// sequences and a random run, all checked against a behavioural model.
module tb_base_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req, done;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       v_a, v_b, to_a, to_b;

  base_arbiter #(.HOLD_MAX(8'd4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(v_a), .timeout(to_a));

  base_arbiter #(.HOLD_MAX(8'd0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(v_b), .timeout(to_b));

  int tests = 0;
  int fails = 0;

  // Model: owner index (-1 = none), cycles the grant has been visible,
  // last owner, and pending timeout pulse, one set per instance.
  int m_owner[2];
  int m_last[2];
  int m_held[2];
  bit m_to[2];
  int hold_cfg[2] = '{4, 0};

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       v;
    logic [1:0] id;
    logic       to;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_last[i]  = 3;
      m_held[i]  = 0;
      m_to[i]    = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (m_owner[i] < 0) begin
        bit found;
        found   = 1'b0;
        m_to[i] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last[i] + k) % 4;
          if (!found && req[c]) begin
            found      = 1'b1;
            m_owner[i] = c;
            m_last[i]  = c;
            m_held[i]  = 1;
          end
        end
      end else if (done[m_owner[i]]) begin
        m_owner[i] = -1;
        m_to[i]    = 1'b0;
      end else if (hold_cfg[i] != 0 && m_held[i] == hold_cfg[i]) begin
        m_owner[i] = -1;
        m_to[i]    = 1'b1;
      end else begin
        m_held[i]++;
        m_to[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [3:0] g;
    logic [1:0] id;
    logic       v, to;
    for (int i = 0; i < 2; i++) begin
      g  = (i == 0) ? gnt_a : gnt_b;
      id = (i == 0) ? id_a  : id_b;
      v  = (i == 0) ? v_a   : v_b;
      to = (i == 0) ? to_a  : to_b;
      chk($sformatf("%s model gnt[%0d]", tag, i), 32'(g),
          (m_owner[i] >= 0) ? (32'd1 << m_owner[i]) : 32'd0);
      chk($sformatf("%s model valid[%0d]", tag, i), 32'(v), 32'(m_owner[i] >= 0));
      chk($sformatf("%s model timeout[%0d]", tag, i), 32'(to), 32'(m_to[i]));
      if (m_owner[i] >= 0)
        chk($sformatf("%s model gnt_id[%0d]", tag, i), 32'(id), 32'(m_owner[i]));
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic v,
                       input logic [1:0] id, input logic to);
    chk({tag, " gnt"}, 32'(gnt_a), 32'(g));
    chk({tag, " valid"}, 32'(v_a), 32'(v));
    chk({tag, " timeout"}, 32'(to_a), 32'(to));
    if (v) chk({tag, " gnt_id"}, 32'(id_a), 32'(id));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare_model(tag);
  endtask

  // Reset asserted between edges, checked before the next edge, released at negedge
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_a({tag, " async"}, 4'b0000, 1'b0, 2'd0, 1'b0);
    chk({tag, " async gnt_b"}, 32'(gnt_b), 32'd0);
    compare_model(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[1]  = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0100, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[8]  = '{4'b1111, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[10] = '{4'b1111, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};

    // Reset with all requests pending
    rst_n = 1'b1;
    req   = 4'b1111;
    done  = 4'b0000;
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    chk_a("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("reset gnt_id", 32'(id_a), 32'd0);
    tick("reset_edge");
    chk_a("reset_edge", 4'b0000, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("first_grant");
    chk_a("first_grant", 4'b0001, 1'b1, 2'd0, 1'b0);
    done = 4'b0001;
    tick("first_release");
    req  = 4'b0000;
    done = 4'b0000;
    tick("settle");

    // Directed vectors: single request, rotation, foreign done, idle done
    for (int i = 0; i < 15; i++) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      tick($sformatf("vec%0d", i));
      chk_a($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].v, tbl[i].id, tbl[i].to);
    end

    // Hold timeout with HOLD_MAX=4, then regrant after the gap
    req  = 4'b0100;
    done = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      tick($sformatf("hold%0d", c));
      chk_a($sformatf("hold%0d", c), 4'b0100, 1'b1, 2'd2, 1'b0);
    end
    tick("timeout");
    chk_a("timeout", 4'b0000, 1'b0, 2'd0, 1'b1);
    chk("no_timeout_b gnt", 32'(gnt_b), 32'h4);
    tick("regrant");
    chk_a("regrant", 4'b0100, 1'b1, 2'd2, 1'b0);

    // Requests raised while busy are not latched; timed-out owner goes last
    req = 4'b0101;
    for (int c = 2; c <= 4; c++) tick($sformatf("rr_hold%0d", c));
    tick("rr_timeout");
    chk_a("rr_timeout", 4'b0000, 1'b0, 2'd0, 1'b1);
    tick("rr_next");
    chk_a("rr_next", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Done on the cycle the limit would fire is a normal release
    for (int c = 2; c <= 4; c++) tick($sformatf("tie_hold%0d", c));
    done = 4'b0001;
    tick("tie_release");
    chk_a("tie_release", 4'b0000, 1'b0, 2'd0, 1'b0);
    done = 4'b0000;
    tick("tie_after");
    chk_a("tie_after", 4'b0100, 1'b1, 2'd2, 1'b0);

    // Reset in the middle of a grant
    mid_reset("reset_busy");
    req = 4'b0010;
    tick("mid_grant");
    chk_a("mid_grant", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b1111;
    mid_reset("mid_reset");
    tick("mid_after");
    chk_a("mid_after", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      req  = 4'($urandom);
      done = ($urandom_range(0, 9) < 3) ? 4'($urandom) : 4'b0000;
      tick("rand");
      if ($urandom_range(0, 399) == 0) mid_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
